// File: rtl/run_event_logger.sv
// -----------------------------------------------------------------------------
// run_event_logger
//
// Records each run of equal bits that an upstream run detector reports.
// While z stays high, the block counts the run length. When z falls, it
// pushes a {kind, length} record into a small FIFO. A consumer drains the
// FIFO with a valid/ready handshake. A record that arrives while the FIFO is
// full is dropped, and this sets a sticky overflow flag.
//
// Parameters
//   DEPTH  record FIFO depth (power of two, 2..16)
//   LEN_W  run-length field width
//
// Ports
//   clk       clock, rising edge
//   aclr      asynchronous active-low reset
//   z         detection flag, high while a 4-long run persists
//   y         upstream state code: 4'b1000 = ones run, 4'b0100 = zeros run
//   rd_ready  consumer accepts the head record this cycle
//   clr_ovf   synchronous clear of overflow (a drop on the same edge wins)
//   rd_valid  FIFO holds at least one record
//   rd_kind   head record kind (1 = ones run, 0 = zeros run)
//   rd_len    head record length in clk cycles (saturating)
//   overflow  sticky: a record was dropped
//   ev_cnt    16-bit count of accepted records, wrapping
//             (only present when RUN_EVENT_LOGGER_COUNT_EN is defined)
//
// Build option: define RUN_EVENT_LOGGER_COUNT_EN to add the ev_cnt port.
// -----------------------------------------------------------------------------
module run_event_logger #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             z,
  input  logic [3:0]       y,
  input  logic             rd_ready,
  input  logic             clr_ovf,
  output logic             rd_valid,
  output logic             rd_kind,
  output logic [LEN_W-1:0] rd_len,
`ifdef RUN_EVENT_LOGGER_COUNT_EN
  output logic             overflow,
  output logic [15:0]      ev_cnt
`else
  output logic             overflow
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic               kind;
  logic [LEN_W-1:0]   len;

  // Each entry holds {kind, len}. The kind bit is the MSB.
  logic [LEN_W:0]     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  logic push;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  // A run ends on the edge that samples z low while in RUN.
  assign push   = (state == RUN) && !z;
  assign pop    = rd_valid && rd_ready;
  assign full   = (count == FULL_CNT);
  // When the FIFO is full, a pop on the same edge frees the slot the push needs.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // Capture FSM. The kind is latched only on entry to RUN, so later
  // changes on y are ignored.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state <= IDLE;
      kind  <= 1'b0;
      len   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register in this block samples the pre-edge values of the others.
      case (state)
        IDLE: begin
          if (z) begin
            state <= RUN;
            kind  <= y[3];
            len   <= LEN_W'(1);
          end
        end
        RUN: begin
          if (z) begin
            if (len != LEN_MAX) len <= len + LEN_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage.
  // NOTE: the memory array has no reset. Entries become visible only
  // through count, and the outputs below are forced low while the FIFO is
  // empty. Reset of the pointers and count is therefore enough.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {kind, len};
  end

  // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
  // wrap naturally.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow. A drop on the same edge takes priority over the clear.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef RUN_EVENT_LOGGER_COUNT_EN
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      ev_cnt <= '0;
    end else if (accept) begin
      ev_cnt <= ev_cnt + 16'd1;
    end
  end
`endif

  // The head outputs are decoded from registers only, so there is no path
  // from z. They are forced to zero while the FIFO is empty, which keeps
  // them at zero out of reset.
  logic [LEN_W:0] head;
  assign head     = mem[rd_ptr];
  assign rd_valid = (count != '0);
  assign rd_kind  = rd_valid & head[LEN_W];
  assign rd_len   = rd_valid ? head[LEN_W-1:0] : '0;

endmodule

// File: tb/tb_run_event_logger.sv
// -----------------------------------------------------------------------------
// tb_run_event_logger
//
// Self-checking bench for run_event_logger at its defaults (DEPTH=4, LEN_W=8).
// A behavioural model tracks the current run and holds the records in a
// queue. The DUT outputs are compared with the model every cycle on the
// falling edge. Directed scenarios cover the documented cases, and a
// randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_run_event_logger;

  localparam int DEPTH   = 4;
  localparam int LEN_W   = 8;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             aclr;
  logic             z;
  logic [3:0]       y;
  logic             rd_ready;
  logic             clr_ovf;
  logic             rd_valid;
  logic             rd_kind;
  logic [LEN_W-1:0] rd_len;
  logic             overflow;
`ifdef RUN_EVENT_LOGGER_COUNT_EN
  logic [15:0]      ev_cnt;
`endif

  run_event_logger #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .aclr     (aclr),
    .z        (z),
    .y        (y),
    .rd_ready (rd_ready),
    .clr_ovf  (clr_ovf),
    .rd_valid (rd_valid),
    .rd_kind  (rd_kind),
    .rd_len   (rd_len),
`ifdef RUN_EVENT_LOGGER_COUNT_EN
    .overflow (overflow),
    .ev_cnt   (ev_cnt)
`else
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit kind;
    int len;
  } rec_t;

  rec_t m_q[$];
  bit   m_in_run;
  bit   m_kind;
  int   m_len;
  bit   m_ovf;
  int   m_cnt;

  task automatic model_reset();
    m_q.delete();
    m_in_run = 0;
    m_kind   = 0;
    m_len    = 0;
    m_ovf    = 0;
    m_cnt    = 0;
  endtask

  // Apply one clock edge with the given inputs to the model.
  task automatic model_step(input bit zz, input logic [3:0] yy, input bit rdy, input bit clr);
    bit   was_full;
    bit   do_pop;
    bit   do_push;
    bit   dropped;
    rec_t r;
    was_full = (m_q.size() == DEPTH);
    do_pop   = (m_q.size() > 0) && rdy;
    do_push  = m_in_run && !zz;
    dropped  = do_push && was_full && !do_pop;
    r.kind   = m_kind;
    r.len    = (m_len < LEN_MAX) ? m_len : LEN_MAX;
    if (do_pop) void'(m_q.pop_front());
    if (do_push && !dropped) begin
      m_q.push_back(r);
      m_cnt = (m_cnt + 1) % 65536;
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (!m_in_run) begin
      if (zz) begin
        m_in_run = 1;
        m_kind   = yy[3];
        m_len    = 1;
      end
    end else if (zz) begin
      m_len++;
    end else begin
      m_in_run = 0;
    end
  endtask

  task automatic compare_all();
    check("rd_valid", rd_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("rd_kind", rd_kind, m_q[0].kind);
      check("rd_len", rd_len, m_q[0].len);
    end else begin
      check("rd_kind_empty", rd_kind, 0);
      check("rd_len_empty", rd_len, 0);
    end
    check("overflow", overflow, m_ovf);
`ifdef RUN_EVENT_LOGGER_COUNT_EN
    check("ev_cnt", ev_cnt, m_cnt);
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  // Each call begins at a falling edge and ends at the next falling edge.
  task automatic cycle(input bit zz, input logic [3:0] yy, input bit rdy, input bit clr);
    z        = zz;
    y        = yy;
    rd_ready = rdy;
    clr_ovf  = clr;
    @(posedge clk);
    model_step(zz, yy, rdy, clr);
    @(negedge clk);
    compare_all();
  endtask

  // A run of n cycles with z high, then one cycle with z low that pushes
  // the record. rdy and clr apply only on that final cycle.
  task automatic run(input int n, input logic [3:0] yy, input bit rdy, input bit clr);
    for (int i = 0; i < n; i++) cycle(1'b1, yy, 1'b0, 1'b0);
    cycle(1'b0, yy, rdy, clr);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    aclr = 1'b0;
    #1;
    model_reset();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_kind", rd_kind, 0);
    check("rst_rd_len", rd_len, 0);
    check("rst_overflow", overflow, 0);
`ifdef RUN_EVENT_LOGGER_COUNT_EN
    check("rst_ev_cnt", ev_cnt, 0);
`endif
    z        = 1'b0;
    y        = 4'b0000;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    aclr = 1'b1;
    compare_all();
  endtask

  initial begin
    aclr     = 1'b0;
    z        = 1'b0;
    y        = 4'b0000;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // A 3-cycle ones run is reported one cycle after z falls.
    run(3, 4'b1000, 1'b0, 1'b0);
    check("r032_valid", rd_valid, 1);
    check("r032_kind", rd_kind, 1);
    check("r032_len", rd_len, 3);
    drain();

    // Three records are held in order, then drained on consecutive edges.
    // y changes during a run must not alter the latched kind.
    run(2, 4'b0100, 1'b0, 1'b0);
    cycle(1'b1, 4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0100, 1'b0, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0, 1'b0);
    run(1, 4'b0100, 1'b0, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0, 1'b0);
    check("r033_head0_kind", rd_kind, 0);
    check("r033_head0_len", rd_len, 2);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);
    check("r033_head1_kind", rd_kind, 1);
    check("r033_head1_len", rd_len, 5);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);
    check("r033_head2_kind", rd_kind, 0);
    check("r033_head2_len", rd_len, 1);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);
    check("r033_empty", rd_valid, 0);

    // Five 1-cycle runs overflow the FIFO, and a clr_ovf pulse clears the flag.
    for (int i = 0; i < 5; i++) run(1, (i % 2 == 0) ? 4'b0100 : 4'b1000, 1'b0, 1'b0);
    check("r034_ovf_set", overflow, 1);
    check("r034_head_kind", rd_kind, 0);
    cycle(1'b0, 4'b0000, 1'b0, 1'b1);
    check("r034_ovf_clr", overflow, 0);

    // Push and pop on the same edge while full: no drop, oldest popped.
    run(1, 4'b1000, 1'b1, 1'b0);
    check("r037_ovf", overflow, 0);
    check("r037_valid", rd_valid, 1);
    check("r037_head_kind", rd_kind, 1);
    // A drop and clr_ovf on the same edge: set wins.
    run(1, 4'b0100, 1'b0, 1'b1);
    check("r026_set_wins", overflow, 1);
    drain();
    cycle(1'b0, 4'b0000, 1'b0, 1'b1);

    // Run length saturates.
    run(300, 4'b1000, 1'b0, 1'b0);
    check("r035_len_sat", rd_len, 255);
    drain();

    // A reset in the middle of a run discards it.
    cycle(1'b1, 4'b1000, 1'b0, 1'b0);
    z = 1'b1;
    #2;
    do_reset();
    cycle(1'b0, 4'b0000, 1'b0, 1'b0);
    run(1, 4'b0100, 1'b0, 1'b0);
    check("r036_valid", rd_valid, 1);
    check("r036_kind", rd_kind, 0);
    check("r036_len", rd_len, 1);
`ifdef RUN_EVENT_LOGGER_COUNT_EN
    check("r036_ev_cnt", ev_cnt, 1);
`endif
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);
    check("r036_only_one", rd_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         rz;
      logic [3:0] ry;
      rz = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 3))
        0:       ry = 4'b0100;
        1:       ry = 4'b1000;
        default: ry = 4'($urandom);
      endcase
      cycle(rz, ry, ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_event_logger.md
RUN_EVENT_LOGGER -- requirements
Module: run_event_logger

Interface
REQ-001 Parameter DEPTH, default 4: record FIFO depth; power of two, 2..16.
REQ-002 Parameter LEN_W, default 8: run-length field width.
REQ-003 clk  input  1: clock; all state changes on its rising edge.
REQ-004 aclr  input  1: reset, asynchronous, active-low.
REQ-005 z  input  1: detection flag from the upstream run detector; high while a 4-long run of equal bits persists.
REQ-006 y  input  4: upstream state code; 4'b1000 = ones run, 4'b0100 = zeros run.
REQ-007 rd_ready  input  1: consumer accepts the head record this cycle.
REQ-008 clr_ovf  input  1: synchronous clear of the overflow flag.
REQ-009 rd_valid  output  1: FIFO holds at least one record.
REQ-010 rd_kind  output  1: head record kind; 1 = ones run, 0 = zeros run.
REQ-011 rd_len  output  LEN_W: head record length in clk cycles.
REQ-012 overflow  output  1: sticky; a record was dropped.

Function
REQ-013 Capture FSM SHALL have two states, IDLE and RUN.
REQ-014 IDLE with z=1 sampled: go to RUN; latch kind = y[3]; set len = 1.
REQ-015 IDLE with z=0: remain in IDLE; no push.
REQ-016 RUN with z=1: remain in RUN; len += 1, saturating at 2^LEN_W-1 (no wrap).
REQ-017 RUN with z=0: push {kind, len} into the FIFO on the same edge; go to IDLE.
REQ-018 Kind SHALL be latched only on IDLE->RUN entry; y changes during RUN are ignored.
REQ-019 A record SHALL appear on rd_valid/rd_kind/rd_len one clock after the edge that samples z=0; no combinational path from z to any output.
REQ-020 Pop occurs on an edge where rd_valid=1 and rd_ready=1; rd_ready with rd_valid=0 has no effect.
REQ-021 rd_kind/rd_len SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-022 FIFO order SHALL be strict first-in first-out; pointers wrap modulo DEPTH.
REQ-023 Push to a full FIFO with no pop on the same edge: record dropped, FIFO unchanged, overflow set.
REQ-024 Push and pop on the same edge when full: both performed, occupancy unchanged, overflow not set.
REQ-025 Push and pop on the same edge when holding one record: new record becomes head, rd_valid stays 1.
REQ-026 clr_ovf=1 clears overflow; if a drop occurs on the same edge, overflow SHALL be 1 (set wins).

Reset
REQ-027 aclr low SHALL immediately force: FSM IDLE, len 0, kind 0, FIFO empty, rd_valid 0, rd_kind 0, rd_len 0, overflow 0.
REQ-028 A run in progress at reset SHALL be discarded, with no partial record.
REQ-029 After aclr deasserts, the first z=1 sample starts a new run.

Configuration
REQ-030 Macro RUN_EVENT_LOGGER_COUNT_EN defined: add output ev_cnt, 16 bits; increments on each accepted push; wraps 16'hFFFF -> 0; not incremented on dropped records; reset 0.
REQ-031 Macro undefined: ev_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 z high 3 cycles with y=4'b1000, then low -> one cycle later rd_valid=1, rd_kind=1, rd_len=3.
REQ-033 Runs of length 2 (y=4'b0100), 5 (y=4'b1000), 1 (y=4'b0100), rd_ready=0 -> three records in order (0,2), (1,5), (0,1); rd_ready=1 drains them on three consecutive edges.
REQ-034 Five 1-cycle runs with rd_ready=0, DEPTH=4 -> first four retained, overflow=1; clr_ovf pulse -> overflow=0.
REQ-035 z held high 300 cycles, LEN_W=8 -> rd_len=255.
REQ-036 aclr low during cycle 2 of a run, released, then 1-cycle run with y=4'b0100 -> only record (0,1); with RUN_EVENT_LOGGER_COUNT_EN, ev_cnt=1.
REQ-037 FIFO full, rd_ready=1 on the push edge -> occupancy stays 4, overflow=0, oldest record popped.
